// File: rtl/dram_bank_responder.sv
// Cycle-level DRAM device model: per-bank open-row FSMs with tRCD/tRP timing,
// a storage array, and a fixed CAS-latency read return pipe.
module dram_bank_responder #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int T_RCD        = 3,
  parameter int T_RP         = 2,
  parameter int CAS_LAT      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              cmd,
  input  logic [NUM_OF_BANKS-1:0] bank_sel,
  input  logic [NUM_OF_ROWS-1:0]  row_sel,
  input  logic [NUM_OF_COLS-1:0]  col_sel,
  input  logic [DATA_WIDTH-1:0]   dram_data_out,
  output logic [DATA_WIDTH-1:0]   dram_data_in,
  output logic                    dram_data_valid,
  output logic [NUM_OF_BANKS-1:0] bank_ready,
  output logic                    cmd_err
);

  localparam int BW    = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
  localparam int RW    = (NUM_OF_ROWS  > 1) ? $clog2(NUM_OF_ROWS)  : 1;
  localparam int CW    = (NUM_OF_COLS  > 1) ? $clog2(NUM_OF_COLS)  : 1;
  localparam int AW    = BW + RW + CW;
  localparam int T_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int TW    = $clog2(T_MAX + 1);

  typedef enum logic [1:0] {
    CMD_NOP = 2'b00,
    CMD_ACT = 2'b01,
    CMD_RD  = 2'b10,
    CMD_WR  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    B_IDLE,
    B_OPENING,
    B_ACTIVE,
    B_CLOSING
  } bank_state_e;

  cmd_e                  cmd_w;
  bank_state_e           state_q [NUM_OF_BANKS];
  bank_state_e           state_d [NUM_OF_BANKS];
  logic [TW-1:0]         timer_q [NUM_OF_BANKS];
  logic [TW-1:0]         timer_d [NUM_OF_BANKS];
  logic [RW-1:0]         row_q   [NUM_OF_BANKS];
  logic [RW-1:0]         row_d   [NUM_OF_BANKS];

  logic [BW-1:0]         bank_idx;
  logic [RW-1:0]         row_idx;
  logic [CW-1:0]         col_idx;
  logic                  bank_oh, row_oh, col_oh;
  bank_state_e           sel_state;
  logic [AW-1:0]         mem_addr;
  logic                  act_ok, rd_ok, wr_ok, err_d;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem_q [2**AW];
  logic [CAS_LAT-1:0]    vld_q;
  logic [DATA_WIDTH-1:0] dat_q [CAS_LAT];

  assign cmd_w = cmd_e'(cmd);

  // One-hot to binary; the result only matters when the select is one-hot.
  always_comb begin
    bank_idx = '0;
    row_idx  = '0;
    col_idx  = '0;
    for (int unsigned i = 0; i < NUM_OF_BANKS; i++)
      if (bank_sel[i]) bank_idx = bank_idx | BW'(i);
    for (int unsigned i = 0; i < NUM_OF_ROWS; i++)
      if (row_sel[i]) row_idx = row_idx | RW'(i);
    for (int unsigned i = 0; i < NUM_OF_COLS; i++)
      if (col_sel[i]) col_idx = col_idx | CW'(i);
  end

  assign bank_oh   = $onehot(bank_sel);
  assign row_oh    = $onehot(row_sel);
  assign col_oh    = $onehot(col_sel);
  assign sel_state = state_q[bank_idx];
  assign mem_addr  = {bank_idx, row_q[bank_idx], col_idx};

  always_comb begin
    act_ok = 1'b0;
    rd_ok  = 1'b0;
    wr_ok  = 1'b0;
    err_d  = 1'b0;
    case (cmd_w)
      CMD_ACT: begin
        if (!bank_oh || !row_oh || sel_state == B_OPENING || sel_state == B_CLOSING)
          err_d = 1'b1;
        else
          act_ok = 1'b1;
      end
      CMD_RD: begin
        if (!bank_oh || !col_oh || sel_state != B_ACTIVE) err_d = 1'b1;
        else rd_ok = 1'b1;
      end
      CMD_WR: begin
        if (!bank_oh || !col_oh || sel_state != B_ACTIVE) err_d = 1'b1;
        else wr_ok = 1'b1;
      end
      default: ;
    endcase
  end

  // Accepted ACTs only hit IDLE/ACTIVE banks, so they never race the timers.
  always_comb begin
    for (int unsigned b = 0; b < NUM_OF_BANKS; b++) begin
      state_d[b] = state_q[b];
      timer_d[b] = timer_q[b];
      row_d[b]   = row_q[b];
      case (state_q[b])
        B_OPENING: begin
          if (timer_q[b] == TW'(1)) state_d[b] = B_ACTIVE;
          else timer_d[b] = timer_q[b] - TW'(1);
        end
        B_CLOSING: begin
          if (timer_q[b] == TW'(1)) begin
            state_d[b] = B_OPENING;
            timer_d[b] = TW'(T_RCD);
          end else begin
            timer_d[b] = timer_q[b] - TW'(1);
          end
        end
        default: ;
      endcase
      if (act_ok && bank_idx == BW'(b)) begin
        if (state_q[b] == B_IDLE) begin
          state_d[b] = B_OPENING;
          timer_d[b] = TW'(T_RCD);
          row_d[b]   = row_idx;
        end else if (state_q[b] == B_ACTIVE && row_q[b] != row_idx) begin
          state_d[b] = B_CLOSING;
          timer_d[b] = TW'(T_RP);
          row_d[b]   = row_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned b = 0; b < NUM_OF_BANKS; b++) begin
        state_q[b] <= B_IDLE;
        timer_q[b] <= '0;
        row_q[b]   <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int unsigned b = 0; b < NUM_OF_BANKS; b++) begin
        state_q[b] <= state_d[b];
        timer_q[b] <= timer_d[b];
        row_q[b]   <= row_d[b];
      end
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[mem_addr] <= dram_data_out;
  end

  // Each data stage loads only behind a valid, so the last stage holds the last read.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < CAS_LAT; k++) dat_q[k] <= '0;
    end else begin
      vld_q[0] <= rd_ok;
      if (rd_ok) dat_q[0] <= mem_q[mem_addr];
      for (int unsigned k = 1; k < CAS_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
      end
    end
  end

  always_comb begin
    bank_ready = '0;
    for (int unsigned b = 0; b < NUM_OF_BANKS; b++)
      bank_ready[b] = (state_q[b] == B_ACTIVE);
  end

  assign dram_data_valid = vld_q[CAS_LAT-1];
  assign dram_data_in    = dat_q[CAS_LAT-1];
  assign cmd_err         = err_q;

endmodule

// File: tb/tb_dram_bank_responder.sv
// Directed bench for dram_bank_responder: timing, data return, error pulses, reset flush.
module tb_dram_bank_responder;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] ACT = 2'b01;
  localparam logic [1:0] RD  = 2'b10;
  localparam logic [1:0] WR  = 2'b11;

  logic         clk;
  logic         rst;
  logic [1:0]   cmd;
  logic [7:0]   bank_sel;
  logic [127:0] row_sel;
  logic [7:0]   col_sel;
  logic [7:0]   dram_data_out;
  logic [7:0]   dram_data_in;
  logic         dram_data_valid;
  logic [7:0]   bank_ready;
  logic         cmd_err;

  int n_checks = 0;
  int n_errors = 0;
  int nv;

  dram_bank_responder #(
    .DATA_WIDTH(8), .NUM_OF_BANKS(8), .NUM_OF_ROWS(128), .NUM_OF_COLS(8),
    .T_RCD(3), .T_RP(2), .CAS_LAT(2)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .bank_sel(bank_sel), .row_sel(row_sel),
    .col_sel(col_sel), .dram_data_out(dram_data_out), .dram_data_in(dram_data_in),
    .dram_data_valid(dram_data_valid), .bank_ready(bank_ready), .cmd_err(cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] c, input logic [7:0] b, input int r,
                        input logic [7:0] cs, input logic [7:0] d);
    cmd = c;
    bank_sel = b;
    row_sel = '0;
    if (r >= 0) row_sel[r] = 1'b1;
    col_sel = cs;
    dram_data_out = d;
    tick();
    cmd = NOP;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cmd = NOP; bank_sel = '0; row_sel = '0; col_sel = '0; dram_data_out = '0;
    tick();
    check("rst_valid", dram_data_valid, 0);
    check("rst_ready", bank_ready, 8'h00);
    check("rst_err", cmd_err, 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_valid", dram_data_valid, 0);
    check("post_rst_ready", bank_ready, 8'h00);
    check("post_rst_err", cmd_err, 0);

    // ACT bank 2 row 5, RD while still opening
    do_cmd(ACT, 8'h04, 5, 8'h00, 8'h00);
    check("act_err", cmd_err, 0);
    check("opening_ready", bank_ready, 8'h00);
    do_cmd(RD, 8'h04, -1, 8'h02, 8'h00);
    check("rd_opening_err", cmd_err, 1);
    tick();
    check("rejected_rd_novalid", dram_data_valid, 0);
    check("ready_not_early", bank_ready, 8'h00);
    check("err_one_cycle", cmd_err, 0);
    tick();
    check("ready_trcd", bank_ready, 8'h04);
    check("rejected_rd_novalid2", dram_data_valid, 0);

    do_cmd(WR, 8'h04, -1, 8'h02, 8'hA5);
    check("wr_err", cmd_err, 0);
    do_cmd(RD, 8'h04, -1, 8'h02, 8'h00);
    check("rd_lat1_valid", dram_data_valid, 0);
    tick();
    check("rd_lat2_valid", dram_data_valid, 1);
    check("rd_lat2_data", dram_data_in, 8'hA5);
    tick();
    check("rd_lat3_valid", dram_data_valid, 0);
    check("rd_hold_data", dram_data_in, 8'hA5);

    // Row change: CLOSING then OPENING
    do_cmd(ACT, 8'h04, 9, 8'h00, 8'h00);
    check("act_diff_err", cmd_err, 0);
    check("act_diff_drop", bank_ready, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("closing_ready", bank_ready, 8'h00);
    end
    tick();
    check("reopen_ready", bank_ready, 8'h04);
    do_cmd(ACT, 8'h04, 9, 8'h00, 8'h00);
    check("act_same_err", cmd_err, 0);
    check("act_same_ready", bank_ready, 8'h04);
    do_cmd(WR, 8'h04, -1, 8'h02, 8'h3C);
    do_cmd(RD, 8'h04, -1, 8'h02, 8'h00);
    tick();
    check("row9_valid", dram_data_valid, 1);
    check("row9_data", dram_data_in, 8'h3C);

    // Second bank opens independently; ACT while opening is rejected
    do_cmd(ACT, 8'h01, 3, 8'h00, 8'h00);
    check("act_b0_err", cmd_err, 0);
    do_cmd(ACT, 8'h01, 4, 8'h00, 8'h00);
    check("act_opening_err", cmd_err, 1);
    tick();
    tick();
    check("two_banks_ready", bank_ready, 8'h05);

    // Error cases
    do_cmd(WR, 8'h05, -1, 8'h02, 8'hFF);
    check("wr_multibank_err", cmd_err, 1);
    do_cmd(RD, 8'h02, -1, 8'h01, 8'h00);
    check("rd_idle_err", cmd_err, 1);
    do_cmd(RD, 8'h04, -1, 8'h06, 8'h00);
    check("rd_col_multi_err", cmd_err, 1);
    do_cmd(ACT, 8'h04, -1, 8'h00, 8'h00);
    check("act_row_zero_err", cmd_err, 1);
    check("act_row_zero_ready", bank_ready, 8'h05);
    do_cmd(NOP, 8'hFF, -1, 8'hFF, 8'h00);
    check("nop_no_err", cmd_err, 0);
    do_cmd(RD, 8'h04, -1, 8'h02, 8'h00);
    tick();
    check("mem_unchanged_valid", dram_data_valid, 1);
    check("mem_unchanged_data", dram_data_in, 8'h3C);

    // Back-to-back reads then reset mid-flight
    do_cmd(WR, 8'h04, -1, 8'h01, 8'h11);
    do_cmd(WR, 8'h04, -1, 8'h02, 8'h22);
    do_cmd(WR, 8'h04, -1, 8'h04, 8'h33);
    do_cmd(WR, 8'h04, -1, 8'h08, 8'h44);
    nv = 0;
    do_cmd(RD, 8'h04, -1, 8'h01, 8'h00);
    if (dram_data_valid) nv++;
    do_cmd(RD, 8'h04, -1, 8'h02, 8'h00);
    if (dram_data_valid) nv++;
    check("b2b_data0", dram_data_in, 8'h11);
    do_cmd(RD, 8'h04, -1, 8'h04, 8'h00);
    if (dram_data_valid) nv++;
    check("b2b_data1", dram_data_in, 8'h22);
    rst = 1'b1;
    do_cmd(RD, 8'h04, -1, 8'h08, 8'h00);
    if (dram_data_valid) nv++;
    check("rst_flush_valid", dram_data_valid, 0);
    check("rst_flush_ready", bank_ready, 8'h00);
    tick();
    if (dram_data_valid) nv++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dram_data_valid) nv++;
    end
    check("b2b_valid_count", nv, 2);
    check("after_rst_ready", bank_ready, 8'h00);
    do_cmd(RD, 8'h04, -1, 8'h01, 8'h00);
    check("rd_after_rst_err", cmd_err, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
